// File: rtl/pulse_train_ctrl.sv
// Pulse train generator: programmable on/off times and pulse count,
// with graceful stop, immediate abort and per-pulse/per-train strobes.
module pulse_train_ctrl #(
    parameter int TIME_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] cfg_ton,
    input  logic [TIME_W-1:0] cfg_toff,
    input  logic [CNT_W-1:0]  cfg_num,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    output logic              pulse_out,
    output logic              busy,
    output logic              pulse_done,
    output logic              train_done,
    output logic              aborted,
    output logic [CNT_W-1:0]  pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t            state;
    logic [TIME_W-1:0] ton_s;
    logic [TIME_W-1:0] toff_s;
    logic [CNT_W-1:0]  num_s;
    logic [TIME_W-1:0] timer;
    logic              stop_pend;

    logic [TIME_W-1:0] off_len;
    logic              on_last;
    logic              off_last;
    logic [CNT_W-1:0]  cnt_inc;
    logic              train_full;
    logic              stop_now;

    // Phase-end and completion decodes from shadow config and timer
    always_comb begin
        off_len    = (toff_s == '0) ? TIME_W'(1) : toff_s;
        on_last    = (timer == (ton_s - TIME_W'(1)));
        off_last   = (timer == (off_len - TIME_W'(1)));
        cnt_inc    = pulse_cnt + CNT_W'(1);
        train_full = (num_s != '0) && (cnt_inc == num_s);
        stop_now   = stop | stop_pend;
    end

    // Main FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ton_s      <= '0;
            toff_s     <= '0;
            num_s      <= '0;
            timer      <= '0;
            stop_pend  <= 1'b0;
            pulse_out  <= 1'b0;
            busy       <= 1'b0;
            pulse_done <= 1'b0;
            train_done <= 1'b0;
            aborted    <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            pulse_done <= 1'b0;
            train_done <= 1'b0;
            aborted    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ton_s     <= cfg_ton;
                        toff_s    <= cfg_toff;
                        num_s     <= cfg_num;
                        pulse_cnt <= '0;
                        timer     <= '0;
                        stop_pend <= 1'b0;
                        if (cfg_ton != '0) begin
                            state     <= ON;
                            pulse_out <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            train_done <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (abort) begin
                        state     <= IDLE;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                        aborted   <= 1'b1;
                        timer     <= '0;
                        stop_pend <= 1'b0;
                    end else if (on_last) begin
                        pulse_cnt  <= cnt_inc;
                        pulse_done <= 1'b1;
                        pulse_out  <= 1'b0;
                        timer      <= '0;
                        if (stop_now || train_full) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            train_done <= 1'b1;
                            stop_pend  <= 1'b0;
                        end else begin
                            state <= OFF;
                        end
                    end else begin
                        timer <= timer + TIME_W'(1);
                        if (stop) begin
                            stop_pend <= 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        timer   <= '0;
                    end else if (stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        train_done <= 1'b1;
                        timer      <= '0;
                    end else if (off_last) begin
                        state     <= ON;
                        pulse_out <= 1'b1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + TIME_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                    timer     <= '0;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule
